// File: rtl/ksa_mp_add_arbiter_pkg.sv
// Shared types and constants for the multi-precision adder arbiter.
package ksa_mp_add_arbiter_pkg;

    localparam int BYTE_W   = 8;
    localparam int NCLIENTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= n; sizes the byte counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ksa_mp_add_arbiter_ksa8_cin.sv
// 8-bit Kogge-Stone prefix adder with carry-in folded in as a generate at
// position -1 (prefix position 0 below holds the carry-in, bit i sits at i+1).
module ksa8_cin
    import ksa_mp_add_arbiter_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] g_b_s;
    logic [BYTE_W-1:0] p_b_s;
    logic [BYTE_W-1:0] g0_s, p0_s;
    logic [BYTE_W-1:0] g1_s, p1_s;
    logic [BYTE_W-1:0] g2_s, p2_s;
    logic [BYTE_W-1:0] g3_s;

    // Bitwise generate/propagate squares.
    assign g_b_s = a & b;
    assign p_b_s = a ^ b;

    // Position 0 carries cin as a pure generate; position j>0 is bit j-1.
    assign g0_s = {g_b_s[BYTE_W-2:0], cin};
    assign p0_s = {p_b_s[BYTE_W-2:0], 1'b0};

    // Three prefix levels of black cells (distance 1, 2, 4).
    always_comb begin
        g1_s = g0_s;
        p1_s = p0_s;
        for (int j = 1; j < BYTE_W; j++) begin
            g1_s[j] = g0_s[j] | (p0_s[j] & g0_s[j-1]);
            p1_s[j] = p0_s[j] & p0_s[j-1];
        end
        g2_s = g1_s;
        p2_s = p1_s;
        for (int j = 2; j < BYTE_W; j++) begin
            g2_s[j] = g1_s[j] | (p1_s[j] & g1_s[j-2]);
            p2_s[j] = p1_s[j] & p1_s[j-2];
        end
        g3_s = g2_s;
        for (int j = 4; j < BYTE_W; j++) begin
            g3_s[j] = g2_s[j] | (p2_s[j] & g2_s[j-4]);
        end
    end

    // g3_s[i] is the carry into bit i; the MSB carry-out needs one more cell.
    assign sum  = p_b_s ^ g3_s;
    assign cout = g_b_s[BYTE_W-1] | (p_b_s[BYTE_W-1] & g3_s[BYTE_W-1]);

endmodule

// File: rtl/ksa_mp_add_arbiter.sv
// Round-robin arbiter in front of one shared 8-bit prefix adder slice; the
// granted operand pair is added LSB byte first, chaining the carry.
module ksa_mp_add_arbiter
    import ksa_mp_add_arbiter_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NCLIENTS-1:0]                req_valid,
    output logic [NCLIENTS-1:0]                req_ready,
    input  logic [NCLIENTS*BYTE_W*NBYTES-1:0]  req_a,
    input  logic [NCLIENTS*BYTE_W*NBYTES-1:0]  req_b,
    input  logic [NCLIENTS-1:0]                req_cin,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic                               rsp_client,
    output logic [BYTE_W*NBYTES-1:0]           rsp_sum,
    output logic                               rsp_cout
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int CW = clog2(NBYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                carry_q, carry_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic                client_q, client_d;
    logic [W-1:0]        sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                valid_q, valid_d;
    logic                pri_q, pri_d;

    logic                gnt_s;
    logic                gnt_vld_s;
    logic [NCLIENTS-1:0] req_ready_s;
    logic [BYTE_W-1:0]   a_byte_s;
    logic [BYTE_W-1:0]   b_byte_s;
    logic [BYTE_W-1:0]   s_byte_s;
    logic                c_s;

    // Round-robin pick: the client not granted last time wins a tie.
    always_comb begin
        gnt_s     = pri_q;
        gnt_vld_s = 1'b0;
        if (req_valid[pri_q]) begin
            gnt_s     = pri_q;
            gnt_vld_s = 1'b1;
        end else if (req_valid[~pri_q]) begin
            gnt_s     = ~pri_q;
            gnt_vld_s = 1'b1;
        end else begin
            gnt_s     = pri_q;
            gnt_vld_s = 1'b0;
        end
    end

    assign a_byte_s = a_q[cnt_q*BYTE_W +: BYTE_W];
    assign b_byte_s = b_q[cnt_q*BYTE_W +: BYTE_W];

    ksa8_cin u_ksa8 (
        .a    (a_byte_s),
        .b    (b_byte_s),
        .cin  (carry_q),
        .sum  (s_byte_s),
        .cout (c_s)
    );

    // Next-state and datapath update for IDLE/RUN/DONE sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        client_d    = client_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        valid_d     = valid_q;
        pri_d       = pri_q;
        req_ready_s = 2'b00;
        case (state_q)
            IDLE: begin
                if (gnt_vld_s) begin
                    req_ready_s = gnt_s ? 2'b10 : 2'b01;
                    a_d         = req_a[gnt_s*W +: W];
                    b_d         = req_b[gnt_s*W +: W];
                    carry_d     = req_cin[gnt_s];
                    client_d    = gnt_s;
                    pri_d       = ~gnt_s;
                    cnt_d       = '0;
                    state_d     = RUN;
                end else begin
                    state_d     = IDLE;
                end
            end
            RUN: begin
                sum_d[cnt_q*BYTE_W +: BYTE_W] = s_byte_s;
                carry_d = c_s;
                if (cnt_q == LAST_IDX) begin
                    cout_d  = c_s;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            client_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            valid_q  <= 1'b0;
            pri_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            client_q <= client_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            valid_q  <= valid_d;
            pri_q    <= pri_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = valid_q;
    assign rsp_client = client_q;
    assign rsp_sum    = sum_q;
    assign rsp_cout   = cout_q;

endmodule

// File: tb/tb_ksa_mp_add_arbiter.sv
// Self-checking bench for ksa_mp_add_arbiter (NBYTES=4).
module tb_ksa_mp_add_arbiter;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]    req_cin;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_client;
    logic [W-1:0]  rsp_sum;
    logic          rsp_cout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ksa_mp_add_arbiter #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_client (rsp_client),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cl;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        int          hold;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain 33-bit addition of the whole operands.
    function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    // One request from client c, called at posedge+1 with the DUT idle.
    task automatic op(input int c, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input int hold,
                      input logic [31:0] esum, input logic ecout);
        int k;
        req_a[c*W +: W] = a;
        req_b[c*W +: W] = b;
        req_cin[c]      = cin;
        req_valid       = (c == 1) ? 2'b10 : 2'b01;
        rsp_ready       = (hold == 0);
        #1;
        k = 0;
        while (req_ready[c] !== 1'b1 && k < 20) begin
            @(posedge clk); #2;
            k++;
        end
        chk("op_grant", (k < 20), 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("op_latency", k, 4);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        chk("op_sum", rsp_sum, esum);
        chk("op_cout", rsp_cout, ecout);
        chk("op_client", rsp_client, c);
        @(posedge clk); #1;
        chk("op_valid_drop", rsp_valid, 1'b0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int naccept;
        int nvalid;
        int acc_cl [4];
        int acc_cyc [4];
        logic [32:0] r;

        tbl[0] = '{0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 32'h00000000, 1'b1};
        tbl[1] = '{0, 32'h00FF00FF, 32'h00010001, 1'b1, 0, 32'h01000101, 1'b0};
        tbl[2] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 32'hFFFFFFFF, 1'b1};
        tbl[3] = '{1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 2, 32'hACF13568, 1'b0};
        tbl[4] = '{0, 32'h80000000, 32'h80000000, 1'b0, 1, 32'h00000000, 1'b1};
        tbl[5] = '{1, 32'h00000000, 32'h00000000, 1'b1, 0, 32'h00000001, 1'b0};

        rst = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; req_cin = 2'b00; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_sum", rsp_sum, 32'h0);
        chk("rst_cout", rsp_cout, 1'b0);
        chk("rst_client", rsp_client, 1'b0);
        rst = 1'b0;

        // Table-driven single-client operations.
        for (int i = 0; i < 6; i++) begin
            op(tbl[i].cl, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].hold, tbl[i].sum, tbl[i].cout);
        end

        // Both clients valid from reset: grants alternate, accepts 6 apart.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        req_a = {32'hF0F0F0F0, 32'h11111111};
        req_b = {32'h0F0F0F10, 32'h22222222};
        req_cin = 2'b10;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        naccept = 0;
        for (int s = 0; s < 40 && naccept < 4; s++) begin
            #1;
            if (req_ready != 2'b00) begin
                chk("rr_onehot", $onehot(req_ready), 1'b1);
                acc_cl[naccept]  = req_ready[1] ? 1 : 0;
                acc_cyc[naccept] = cyc;
                naccept++;
            end
            if (rsp_valid === 1'b1) begin
                chk("rr_owner", rsp_client, acc_cl[naccept-1]);
                if (rsp_client) begin
                    r = model_add(32'hF0F0F0F0, 32'h0F0F0F10, 1'b1);
                end else begin
                    r = model_add(32'h11111111, 32'h22222222, 1'b0);
                end
                chk("rr_sum", rsp_sum, r[31:0]);
                chk("rr_cout", rsp_cout, r[32]);
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        chk("rr_naccept", naccept, 4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", acc_cl[i], i % 2);
        end
        for (int i = 1; i < 4; i++) begin
            chk("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 6);
        end
        repeat (8) @(posedge clk);
        #1;

        // Response back-pressure in DONE while client 1 waits.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        req_a = {32'hAAAAAAAA, 32'h01020304};
        req_b = {32'h55555555, 32'h10203040};
        req_cin = 2'b10;
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        chk("bp_ready0", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b10;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("bp_latency", k, 4);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_sum", rsp_sum, 32'h11223344);
            chk("bp_cout", rsp_cout, 1'b0);
            chk("bp_client", rsp_client, 1'b0);
            chk("bp_ready_block", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_hs", req_ready, 2'b00);
        @(posedge clk); #2;
        chk("bp_valid_drop", rsp_valid, 1'b0);
        chk("bp_ready1", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        r = model_add(32'hAAAAAAAA, 32'h55555555, 1'b1);
        chk("bp1_latency", k, 4);
        chk("bp1_sum", rsp_sum, r[31:0]);
        chk("bp1_cout", rsp_cout, r[32]);
        chk("bp1_client", rsp_client, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during the second RUN cycle abandons the operation.
        req_a = {32'h00000000, 32'h00000055};
        req_b = {32'h00000000, 32'h00000011};
        req_cin = 2'b00;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        chk("rs_ready0", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rs_valid", rsp_valid, 1'b0);
        chk("rs_sum", rsp_sum, 32'h0);
        chk("rs_cout", rsp_cout, 1'b0);
        chk("rs_client", rsp_client, 1'b0);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b0) nvalid++;
            @(posedge clk); #1;
        end
        chk("rs_no_rsp", nvalid, 0);
        req_a = {32'h00000003, 32'h00000007};
        req_b = {32'h00000004, 32'h00000009};
        req_valid = 2'b11;
        #1;
        chk("rs_prio", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rs2_latency", k, 4);
        chk("rs2_sum", rsp_sum, 32'h00000010);
        chk("rs2_client", rsp_client, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rc;
            int          cl;
            int          hd;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            cl = $urandom_range(0, 1);
            hd = $urandom_range(0, 3);
            r  = model_add(ra, rb, rc);
            op(cl, ra, rb, rc, hd, r[31:0], r[32]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
